// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: bus command encodings, responder FSM
// states and the address-region decode.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        MEM_NONE    = 2'b00,
        MEM_WRITE   = 2'b01,
        MEM_READ    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_LED  = 2'd1,
        REG_SW   = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    localparam int CNT_W = 4;

    function automatic region_e decode(input int unsigned addr,
                                       input int unsigned depth,
                                       input int unsigned led_addr,
                                       input int unsigned sw_addr);
        region_e r;
        if (addr < depth)          r = REG_RAM;
        else if (addr == led_addr) r = REG_LED;
        else if (addr == sw_addr)  r = REG_SW;
        else                       r = REG_NONE;
        return r;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory bus: command/address/data from the controller and the
// one-cycle ready/error response from the responder.
interface mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
);
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              mem_err;
    logic              busy;

    modport master (
        output mem_cmd, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, mem_err, busy
    );

    modport slave (
        input  mem_cmd, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, mem_err, busy
    );
endinterface

// File: rtl/mem_responder_ram.sv
// Single-port synchronous RAM with a registered read; contents are never reset
// so it maps onto block RAM.
module ram_sp #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: services read/write commands after WAIT_STATES cycles,
// decoding RAM, an LED register and a synchronized switch port.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          ADDR_W      = 9,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1,
    parameter int unsigned LED_ADDR    = 'h100,
    parameter int unsigned SW_ADDR     = 'h140
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus,
    input  logic [7:0]     sw_in_i,
    output logic [7:0]     led_out_o
);
    localparam int AW = $clog2(MEM_DEPTH);

    if (WAIT_STATES > 15 || WAIT_STATES < 0) begin : g_bad_wait_states
        $error("mem_responder: WAIT_STATES must be in 0..15");
    end

    resp_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        sw_meta_q, sw_sync_q, led_q;
    logic              ready_q, err_q, busy_q;
    logic [DATA_W-1:0] rdata_reg_q, rdata_reg_d;
    logic              rdata_from_ram_q;

    logic              enter_resp, rd_now, err_now;
    logic              ram_we, ram_re, led_ld;
    logic [1:0]        eff_cmd;
    logic [ADDR_W-1:0] eff_addr;
    region_e           eff_region, resp_region;
    logic [AW-1:0]     ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.mem_cmd != MEM_NONE) begin
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the response is set up on the acceptance edge,
    // before the command registers hold it, so look at the live bus instead.
    assign eff_cmd     = (state_q == IDLE) ? bus.mem_cmd  : cmd_q;
    assign eff_addr    = (state_q == IDLE) ? bus.mem_addr : addr_q;
    assign eff_region  = decode(32'(eff_addr), MEM_DEPTH, LED_ADDR, SW_ADDR);
    assign resp_region = decode(32'(addr_q), MEM_DEPTH, LED_ADDR, SW_ADDR);

    assign rd_now  = enter_resp && (eff_cmd == MEM_READ);
    assign err_now = (eff_cmd == MEM_ILLEGAL) || (eff_region == REG_NONE) ||
                     ((eff_cmd == MEM_WRITE) && (eff_region == REG_SW));

    assign ram_re   = rd_now && (eff_region == REG_RAM);
    assign ram_we   = (state_q == RESP) && (cmd_q == MEM_WRITE) && (resp_region == REG_RAM);
    assign led_ld   = (state_q == RESP) && (cmd_q == MEM_WRITE) && (resp_region == REG_LED);
    assign ram_addr = ram_we ? addr_q[AW-1:0] : eff_addr[AW-1:0];

    always_comb begin
        rdata_reg_d = '0;
        case (eff_region)
            REG_LED: rdata_reg_d = {{(DATA_W-8){1'b0}}, led_q};
            REG_SW:  rdata_reg_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
            default: rdata_reg_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cmd_q            <= MEM_NONE;
            addr_q           <= '0;
            wdata_q          <= '0;
            sw_meta_q        <= '0;
            sw_sync_q        <= '0;
            led_q            <= '0;
            ready_q          <= 1'b0;
            err_q            <= 1'b0;
            busy_q           <= 1'b0;
            rdata_reg_q      <= '0;
            rdata_from_ram_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sw_meta_q <= sw_in_i;
            sw_sync_q <= sw_meta_q;
            ready_q   <= enter_resp;
            err_q     <= enter_resp && err_now;
            busy_q    <= (state_d != IDLE);
            if (state_q == IDLE && bus.mem_cmd != MEM_NONE) begin
                cmd_q   <= bus.mem_cmd;
                addr_q  <= bus.mem_addr;
                wdata_q <= bus.mem_wdata;
            end
            if (led_ld) led_q <= wdata_q[7:0];
            // Only reads update the returned data; writes and illegal commands hold it.
            if (rd_now) begin
                rdata_reg_q      <= rdata_reg_d;
                rdata_from_ram_q <= (eff_region == REG_RAM);
            end
        end
    end

    ram_sp #(.DEPTH(MEM_DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(wdata_q),
        .rdata_o(ram_rdata)
    );

    assign bus.mem_rdata = rdata_from_ram_q ? ram_rdata : rdata_reg_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
    assign bus.busy      = busy_q;
    assign led_out_o     = led_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with one wait state, one with none,
// checked against a small reference model through a scoreboard queue.
module tb_mem_responder;
    import mem_bus_pkg::*;

    typedef struct {
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] sw0, sw1, led0, led1;

    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(16), .ADDR_W(9)) bus0 ();
    mem_responder_if #(.DATA_W(16), .ADDR_W(9)) bus1 ();

    mem_responder #(.WAIT_STATES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave), .sw_in_i(sw0), .led_out_o(led0));
    mem_responder #(.WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .sw_in_i(sw1), .led_out_o(led1));

    exp_t        sb_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          n_txn0 = 0, n_txn1 = 0, n_rdy0 = 0, n_rdy1 = 0;
    logic [15:0] m_ram  [2][256];
    logic [7:0]  m_led  [2];
    logic [15:0] m_last [2];

    always @(negedge clk) begin
        if (bus0.mem_ready === 1'b1) n_rdy0++;
        if (bus1.mem_ready === 1'b1) n_rdy1++;
    end

    task automatic drive(input int which, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        if (which == 0) begin
            bus0.mem_cmd = c; bus0.mem_addr = a; bus0.mem_wdata = d;
        end else begin
            bus1.mem_cmd = c; bus1.mem_addr = a; bus1.mem_wdata = d;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic er, output logic bs,
                          output logic [15:0] rd, output logic [7:0] ld);
        if (which == 0) begin
            rdy = bus0.mem_ready; er = bus0.mem_err; bs = bus0.busy; rd = bus0.mem_rdata; ld = led0;
        end else begin
            rdy = bus1.mem_ready; er = bus1.mem_err; bs = bus1.busy; rd = bus1.mem_rdata; ld = led1;
        end
    endtask

    // Starts in IDLE just after a clock edge; returns one edge after the response.
    task automatic access(input int which, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        exp_t        e, got;
        logic        rdy, er, bs;
        logic [15:0] rd;
        logic [7:0]  ld, swv;
        int          lat, busy_n, exp_lat, region;
        swv     = (which == 0) ? sw0 : sw1;
        exp_lat = (which == 0) ? 2 : 1;
        if (a < 9'd256)        region = 0;
        else if (a == 9'h100)  region = 1;
        else if (a == 9'h140)  region = 2;
        else                   region = 3;
        e.err = 1'b0;
        e.rdata = m_last[which];
        case (c)
            MEM_READ: begin
                e.err = (region == 3);
                case (region)
                    0:       e.rdata = m_ram[which][a[7:0]];
                    1:       e.rdata = {8'h00, m_led[which]};
                    2:       e.rdata = {8'h00, swv};
                    default: e.rdata = 16'h0000;
                endcase
                m_last[which] = e.rdata;
            end
            MEM_WRITE: begin
                e.err = (region >= 2);
                if (region == 0) m_ram[which][a[7:0]] = d;
                if (region == 1) m_led[which] = d[7:0];
            end
            default: e.err = 1'b1;
        endcase
        sb_q.push_back(e);
        if (which == 0) n_txn0++; else n_txn1++;

        drive(which, c, a, d);
        lat = 0; busy_n = 0; rdy = 1'b0;
        er = 1'b0; bs = 1'b0; rd = '0; ld = '0;
        while (rdy !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            sample(which, rdy, er, bs, rd, ld);
            if (bs === 1'b1) busy_n++;
        end
        drive(which, MEM_NONE, 9'h000, 16'h0000);
        got.err = er; got.rdata = rd;
        e = sb_q.pop_front();

        n_cmp++;
        if (rdy !== 1'b1) begin
            n_bad++; $display("FAIL ready_timeout dut%0d cmd=%b addr=%h: no ready within 20 cycles", which, c, a);
        end else begin
            n_cmp++;
            if (lat != exp_lat) begin
                n_bad++; $display("FAIL latency dut%0d: got %0d cycles, want %0d", which, lat, exp_lat);
            end
            n_cmp++;
            if (got.err !== e.err) begin
                n_bad++; $display("FAIL err dut%0d cmd=%b addr=%h: got %b want %b", which, c, a, got.err, e.err);
            end
            n_cmp++;
            if (got.rdata !== e.rdata) begin
                n_bad++; $display("FAIL rdata dut%0d cmd=%b addr=%h: got %h want %h", which, c, a, got.rdata, e.rdata);
            end
        end

        @(posedge clk); #1;
        sample(which, rdy, er, bs, rd, ld);
        if (bs === 1'b1) busy_n++;
        n_cmp++;
        if (rdy !== 1'b0 || er !== 1'b0) begin
            n_bad++; $display("FAIL pulse_width dut%0d: ready=%b err=%b one cycle after response, want 0/0", which, rdy, er);
        end
        n_cmp++;
        if (busy_n != exp_lat) begin
            n_bad++; $display("FAIL busy_cycles dut%0d: got %0d want %0d", which, busy_n, exp_lat);
        end
        n_cmp++;
        if (ld !== m_led[which]) begin
            n_bad++; $display("FAIL led dut%0d: got %h want %h", which, ld, m_led[which]);
        end
        $display("txn dut%0d cmd=%b addr=%h wdata=%h -> err=%b rdata=%h lat=%0d", which, c, a, d, got.err, got.rdata, lat);
    endtask

    task automatic test_reset();
        drive(0, MEM_NONE, 9'h000, 16'h0000);
        drive(1, MEM_NONE, 9'h000, 16'h0000);
        sw0 = 8'h00; sw1 = 8'h00;
        #1 rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({bus0.mem_ready, bus0.mem_err, bus0.busy, bus0.mem_rdata, led0} !== 27'h0) begin
            n_bad++; $display("FAIL reset_dut0: rdy=%b err=%b busy=%b rdata=%h led=%h, want all 0",
                              bus0.mem_ready, bus0.mem_err, bus0.busy, bus0.mem_rdata, led0);
        end
        n_cmp++;
        if ({bus1.mem_ready, bus1.mem_err, bus1.busy, bus1.mem_rdata, led1} !== 27'h0) begin
            n_bad++; $display("FAIL reset_dut1: rdy=%b err=%b busy=%b rdata=%h led=%h, want all 0",
                              bus1.mem_ready, bus1.mem_err, bus1.busy, bus1.mem_rdata, led1);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_led[i] = 8'h00; m_last[i] = 16'h0000;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ram_rw();
        access(0, MEM_WRITE, 9'd5, 16'hBEEF);
        access(0, MEM_READ,  9'd5, 16'h0000);
    endtask

    task automatic test_led();
        access(0, MEM_WRITE, 9'h100, 16'h00A5);
        n_cmp++;
        if (led0 !== 8'hA5) begin
            n_bad++; $display("FAIL led_load: got %h want a5", led0);
        end
        access(0, MEM_READ, 9'h100, 16'h0000);
    endtask

    task automatic test_switch();
        sw0 = 8'h3C;
        repeat (3) @(posedge clk);
        #1;
        access(0, MEM_READ,  9'h140, 16'h0000);
        access(0, MEM_WRITE, 9'h140, 16'h0077);
        access(0, MEM_READ,  9'd5,   16'h0000);
    endtask

    task automatic test_errors();
        access(0, MEM_READ,    9'h1FF, 16'h0000);
        access(0, MEM_ILLEGAL, 9'd5,   16'h1111);
        access(0, MEM_READ,    9'd5,   16'h0000);
        access(0, MEM_ILLEGAL, 9'h100, 16'h00FF);
    endtask

    task automatic test_reset_abort();
        access(0, MEM_WRITE, 9'd7, 16'h1234);
        access(0, MEM_READ,  9'd5, 16'h0000);
        drive(0, MEM_WRITE, 9'd7, 16'hDEAD);
        @(posedge clk); #1;
        n_cmp++;
        if (bus0.busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_setup: busy=%b want 1 in WAIT", bus0.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus0.mem_ready, bus0.mem_err, bus0.busy, bus0.mem_rdata, led0} !== 27'h0) begin
            n_bad++; $display("FAIL abort_outputs: rdy=%b err=%b busy=%b rdata=%h led=%h, want all 0",
                              bus0.mem_ready, bus0.mem_err, bus0.busy, bus0.mem_rdata, led0);
        end
        drive(0, MEM_NONE, 9'h000, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_led[i] = 8'h00; m_last[i] = 16'h0000;
        end
        @(posedge clk); #1;
        access(0, MEM_READ, 9'd7, 16'h0000);
    endtask

    task automatic test_back_to_back();
        access(1, MEM_WRITE, 9'd1, 16'h1111);
        access(1, MEM_WRITE, 9'd2, 16'h2222);
        access(1, MEM_READ,  9'd1, 16'h0000);
        access(1, MEM_READ,  9'd2, 16'h0000);
        access(1, MEM_WRITE, 9'h100, 16'h005A);
        access(1, MEM_READ,  9'h1C0, 16'h0000);
    endtask

    task automatic test_pulse_count();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (n_rdy0 != n_txn0) begin
            n_bad++; $display("FAIL ready_count dut0: got %0d pulses want %0d", n_rdy0, n_txn0);
        end
        n_cmp++;
        if (n_rdy1 != n_txn1) begin
            n_bad++; $display("FAIL ready_count dut1: got %0d pulses want %0d", n_rdy1, n_txn1);
        end
    endtask

    initial begin
        test_reset();
        test_ram_rw();
        test_led();
        test_switch();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        test_pulse_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU controller's mem_cmd/mem_addr bus: it services read and write commands with a programmable number of wait states and returns a one-cycle ready handshake. It decodes the address into internal RAM, an LED output register, or a switch input port, and flags unmapped accesses. It sits between the CPU datapath/controller and on-chip storage/IO and replaces the combinational RAM hookup.

Parameters:
DATA_W, 16, data word width
ADDR_W, 9, address width
MEM_DEPTH, 256, RAM words, mapped at addresses 0..MEM_DEPTH-1
WAIT_STATES, 1, extra cycles between command acceptance and response (0..15)
LED_ADDR, 9'h100, address of the LED register (read/write)
SW_ADDR, 9'h140, address of the switch port (read-only)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
mem_cmd  in  2  00 none, 10 read, 01 write, 11 illegal
mem_addr  in  ADDR_W  word address, sampled on acceptance
mem_wdata  in  DATA_W  write data, sampled on acceptance
mem_rdata  out  DATA_W  read data, registered
mem_ready  out  1  one-cycle pulse: access complete
mem_err  out  1  one-cycle pulse with mem_ready: unmapped, illegal or read-only-write access
busy  out  1  high in WAIT and RESP
sw_in  in  8  asynchronous switch inputs
led_out  out  8  LED register

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; mem_rdata=0, mem_ready=0, mem_err=0, busy=0, led_out=0, wait counter=0, switch synchronizer=0. RAM contents are not cleared. Reset mid-access aborts it with no write committed.
- FSM states:
  - IDLE: if mem_cmd!=00, capture cmd/addr/wdata on the clock edge. Next state is WAIT with counter=WAIT_STATES, or RESP directly if WAIT_STATES=0.
  - WAIT: counter decrements each cycle; when counter==1, next state is RESP.
  - RESP: mem_ready=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency: command seen in cycle 0 (IDLE) gives mem_ready high in cycle 1+WAIT_STATES.
- Commands arriving while busy are ignored. The initiator holds mem_cmd/addr until ready, then drops or changes them in the following cycle. A held command is re-accepted in IDLE; this is harmless because reads and writes are idempotent.
- Decode on captured addr:
  - addr<MEM_DEPTH: RAM.
  - addr==LED_ADDR: LED register.
  - addr==SW_ADDR: switches.
  - Otherwise: unmapped.
- Read:
  - RAM is a synchronous read, with the address presented on the edge entering RESP, so mem_rdata is valid during RESP.
  - LED reads return {8'b0, led_out}; SW reads return {8'b0, synchronized sw_in}.
  - mem_rdata holds its value until the next read response.
- Write:
  - RAM write enable and LED load are asserted during RESP and take effect on the edge leaving RESP.
  - LED takes wdata[7:0].
- Errors:
  - Unmapped read or write: mem_err=1 with ready. A read returns 0; a write has no effect.
  - Write to SW_ADDR: mem_err=1, no effect.
  - Command 11: accepted as normal, completes with mem_err=1 and no side effects, and mem_rdata is unchanged.
- sw_in passes through a 2-flop synchronizer, so a switch change is visible 2 cycles later.
- The counter is 4 bits wide. WAIT_STATES>15 is a compile-time error (elaboration assertion).

Decomposition:
- Package mem_bus_pkg: mem_cmd encodings (MEM_NONE, MEM_READ, MEM_WRITE) and the responder state enum (IDLE, WAIT, RESP).
- Sub-module ram_sp: single-port synchronous RAM (DEPTH, DATA_W) with one write enable and a registered read; the RAM is instantiated once.

Test Plan:
- WAIT_STATES=1: write 16'hBEEF to addr 5, then read addr 5 -> ready in cycle 2 of each access; rdata=16'hBEEF, err=0.
- Write 16'h00A5 to 9'h100, then read 9'h100 -> led_out=8'hA5 after the write's RESP edge; read returns 16'h00A5.
- sw_in=8'h3C held, then read 9'h140 -> rdata=16'h003C; a write to 9'h140 gives err=1 and leaves led_out and RAM unchanged.
- Read 9'h1FF, then issue mem_cmd=11 -> each completes with ready=1 and err=1 (read gives rdata=0; cmd 11 leaves rdata unchanged).
- Write to addr 7 with reset pulsed low during WAIT -> outputs return to 0 at once, and a later read of addr 7 returns the prior value.
- WAIT_STATES=0: back-to-back reads of addrs 1 and 2 -> ready one cycle after each acceptance, and busy never exceeds one cycle per access.
